// File: rtl/pe_pkg.sv
// Shared op encoding, modulus constant sets and elaboration-time helpers for the
// parametrised butterfly PE.
package pe_pkg;

  typedef enum logic [1:0] {
    OP_CT  = 2'd0,
    OP_GS  = 2'd1,
    OP_PWM = 2'd2,
    OP_BYP = 2'd3
  } op_e;

  localparam int KYBER_W = 12;
  localparam int KYBER_Q = 3329;
  localparam int DIL_W   = 23;
  localparam int DIL_Q   = 8380417;

  // With k = 2*ceil(log2 Q) and x < Q^2 <= 2^k, the quotient estimate is at most
  // one below exact, so one conditional subtract finishes the reduction.
  function automatic int barrett_k(input int q);
    return 2 * $clog2(q);
  endfunction

  function automatic longint barrett_m(input int q);
    return (longint'(1) << barrett_k(q)) / longint'(q);
  endfunction

  function automatic int inv2(input int q);
    return (q + 1) / 2;
  endfunction

endpackage

// File: rtl/pe_bfly_param_mod_mul.sv
// Stallable pipelined a*b mod Q: product register, Barrett reduction register,
// then plain delay stages up to MUL_LAT.
module mod_mul_red_p
  import pe_pkg::*;
#(
  parameter int W       = 12,
  parameter int Q       = 3329,
  parameter int MUL_LAT = 3
) (
  input  logic         clk,
  input  logic         i_en,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_p
);

  localparam int             PW = 2 * W;
  localparam int             BK = barrett_k(Q);
  localparam logic [W+1:0]   BM = (W+2)'(barrett_m(Q));
  localparam logic [W:0]     QW = (W+1)'(Q);

  function automatic logic [W-1:0] reduce(input logic [PW-1:0] x);
    logic [PW+W+1:0] xm;
    logic [W+1:0]    qh;
    logic [PW+1:0]   qq;
    logic [W:0]      r;
    xm = (PW+W+2)'(x) * (PW+W+2)'(BM);
    qh = (W+2)'(xm >> BK);
    qq = (PW+2)'(qh) * (PW+2)'(QW);
    // Remainder is below 2Q, so W+1 bits hold it exactly.
    r  = (W+1)'((PW+2)'(x) - qq);
    return (r >= QW) ? W'(r - QW) : W'(r);
  endfunction

  logic [PW-1:0] w_prod;
  assign w_prod = PW'(i_a) * PW'(i_b);

  generate
    if (MUL_LAT == 1) begin : g_one
      logic [W-1:0] r_p;
      always_ff @(posedge clk) begin
        if (i_en) r_p <= reduce(w_prod);
      end
      assign o_p = r_p;
    end else begin : g_multi
      logic [PW-1:0]             r_prod;
      logic [MUL_LAT-2:0][W-1:0] r_red;
      always_ff @(posedge clk) begin
        if (i_en) begin
          r_prod   <= w_prod;
          r_red[0] <= reduce(r_prod);
          for (int i = 1; i < MUL_LAT - 1; i++) r_red[i] <= r_red[i-1];
        end
      end
      assign o_p = r_red[MUL_LAT-2];
    end
  endgenerate

endmodule

// File: rtl/pe_bfly_param.sv
// Multi-mode butterfly PE: CT/GS/PWM/BYPASS per beat over LANES packed lanes,
// one fixed latency (MUL_LAT+2) and one global stall for every op.
module pe_bfly_param
  import pe_pkg::*;
#(
  parameter int W       = KYBER_W,
  parameter int Q       = KYBER_Q,
  parameter int LANES   = 2,
  parameter int MUL_LAT = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_op,
  input  logic                         in_half,
  input  logic [LANES*W-1:0]           in_a,
  input  logic [LANES*W-1:0]           in_b,
  input  logic [LANES*W-1:0]           in_w,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*W-1:0]           out_x,
  output logic [LANES*W-1:0]           out_y,
  output logic                         busy,
  output logic [$clog2(MUL_LAT+3)-1:0] inflight
);

  localparam int         L  = MUL_LAT + 2;
  localparam int         IW = $clog2(MUL_LAT + 3);
  localparam logic [W:0] QW = (W+1)'(Q);

  typedef logic [LANES-1:0][W-1:0] vec_t;

  function automatic logic [W-1:0] add_q(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= QW) ? W'(s - QW) : W'(s);
  endfunction

  function automatic logic [W-1:0] sub_q(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] d;
    d = {1'b0, a} - {1'b0, b};
    return (a < b) ? W'(d + QW) : W'(d);
  endfunction

  // Odd values become even by adding Q (odd), so the shift is exact mod Q.
  function automatic logic [W-1:0] half_q(input logic [W-1:0] v);
    logic [W:0] t;
    t = {1'b0, v} + (v[0] ? QW : '0);
    return W'(t >> 1);
  endfunction

  logic w_en, w_acc, w_done;
  assign w_en   = ~out_valid | out_ready;
  assign w_acc  = in_valid & w_en;
  assign w_done = out_valid & out_ready;

  logic [L-1:0]   r_vld_pipe;
  logic [IW-1:0]  r_inflight;
  vec_t           r_x, r_y;

  op_e            r0_op;
  logic           r0_half;
  vec_t           r0_a, r0_b, r0_w;

  op_e            r_dop   [MUL_LAT];
  logic [MUL_LAT-1:0] r_dhalf;
  vec_t           r_dp    [MUL_LAT];
  vec_t           r_dq    [MUL_LAT];

  vec_t           w_mx, w_p, w_m, w_ox, w_oy;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [W-1:0] w_s, w_d, w_pp, w_qq, w_mm, w_nx, w_ny;

    assign w_s     = add_q(r0_a[g], r0_b[g]);
    assign w_d     = sub_q(r0_a[g], r0_b[g]);
    // Multiplier input: b for CT, (a-b) for GS, a for PWM; w is always the other factor.
    assign w_mx[g] = (r0_op == OP_GS)  ? w_d :
                     (r0_op == OP_PWM) ? r0_a[g] : r0_b[g];
    assign w_p[g]  = (r0_op == OP_GS)  ? w_s : r0_a[g];

    mod_mul_red_p #(.W(W), .Q(Q), .MUL_LAT(MUL_LAT)) u_mul (
      .clk  (clk),
      .i_en (w_en),
      .i_a  (w_mx[g]),
      .i_b  (r0_w[g]),
      .o_p  (w_m[g])
    );

    assign w_pp = r_dp[MUL_LAT-1][g];
    assign w_qq = r_dq[MUL_LAT-1][g];
    assign w_mm = w_m[g];

    always_comb begin
      w_nx = w_pp;
      w_ny = w_qq;
      case (r_dop[MUL_LAT-1])
        OP_CT: begin
          w_nx = add_q(w_pp, w_mm);
          w_ny = sub_q(w_pp, w_mm);
        end
        OP_GS: begin
          w_nx = r_dhalf[MUL_LAT-1] ? half_q(w_pp) : w_pp;
          w_ny = r_dhalf[MUL_LAT-1] ? half_q(w_mm) : w_mm;
        end
        OP_PWM:  w_nx = w_mm;
        default: ;
      endcase
    end

    assign w_ox[g] = w_nx;
    assign w_oy[g] = w_ny;
  end

  // Control state and visible outputs carry the async reset; pure data does not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld_pipe <= '0;
      r_inflight <= '0;
      r_x        <= '0;
      r_y        <= '0;
    end else begin
      if (w_en) begin
        r_vld_pipe <= {r_vld_pipe[L-2:0], w_acc};
        if (r_vld_pipe[L-2]) begin
          r_x <= w_ox;
          r_y <= w_oy;
        end
      end
      case ({w_acc, w_done})
        2'b10:   r_inflight <= r_inflight + IW'(1);
        2'b01:   r_inflight <= r_inflight - IW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r0_op   <= op_e'(in_op);
      r0_half <= in_half;
      r0_a    <= in_a;
      r0_b    <= in_b;
      r0_w    <= in_w;
    end
    if (w_en) begin
      r_dop[0]   <= r0_op;
      r_dhalf[0] <= r0_half;
      r_dp[0]    <= w_p;
      r_dq[0]    <= r0_b;
      for (int i = 1; i < MUL_LAT; i++) begin
        r_dop[i]   <= r_dop[i-1];
        r_dhalf[i] <= r_dhalf[i-1];
        r_dp[i]    <= r_dp[i-1];
        r_dq[i]    <= r_dq[i-1];
      end
    end
  end

  assign in_ready  = w_en;
  assign out_valid = r_vld_pipe[L-1];
  assign out_x     = r_x;
  assign out_y     = r_y;
  assign inflight  = r_inflight;
  assign busy      = (r_inflight != '0);

endmodule
